// File: rtl/mips_sequencer.sv
// mips_sequencer: multicycle MIPS control sequencer (FETCH/DECODE/EXEC/MDWAIT/HALT/FAULT).
// Optional waitrequest watchdog is compiled in with `define SEQ_WATCHDOG_EN.
module mips_sequencer #(
    parameter int MD_LATENCY = 32,
    parameter int TIMEOUT_W  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] function_code,
    input  logic       waitrequest,
    input  logic       pc_zero,
    output logic [2:0] state,
    output logic       active,
    output logic       read,
    output logic       write,
    output logic       ir_load,
    output logic       pc_we,
    output logic       reg_commit,
    output logic       hilo_commit,
    output logic       stall,
    output logic       fault
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MDWAIT = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;
    localparam logic [2:0] S_FAULT  = 3'd5;
    // EXEC is the first of the MD_LATENCY cycles, so MDWAIT counts down from MD_LATENCY-2.
    localparam logic [7:0] MD_INIT  = MD_LATENCY > 1 ? 8'(MD_LATENCY - 2) : 8'd0;
    localparam logic       MD_ONE   = MD_LATENCY == 1;

    logic [2:0] state_q, state_d;
    logic [7:0] md_cnt_q, md_cnt_d;
    logic       is_load, is_store, is_mem, is_md;
    logic       in_f, in_e, in_m, mem_stall, md_done, run, wd_trip;

    assign is_load   = opcode >= 6'd32 && opcode <= 6'd38;
    assign is_store  = opcode == 6'd40 || opcode == 6'd41 || opcode == 6'd43;
    assign is_mem    = is_load || is_store;
    assign is_md     = opcode == 6'd0 && function_code >= 6'd24 && function_code <= 6'd27;
    assign in_f      = state_q == S_FETCH;
    assign in_e      = state_q == S_EXEC;
    assign in_m      = state_q == S_MDWAIT;
    assign mem_stall = waitrequest && ((in_f && !pc_zero) || (in_e && is_mem));
    assign md_done   = (in_e && is_md && MD_ONE) || (in_m && md_cnt_q == 8'd0);
    assign run       = !reset;

`ifdef SEQ_WATCHDOG_EN
    logic [TIMEOUT_W-1:0] wd_cnt_q, wd_cnt_d;
    assign wd_cnt_d = mem_stall ? wd_cnt_q + 1'b1 : '0;
    // Trip on the stall cycle that brings the count to all-ones.
    assign wd_trip  = mem_stall && wd_cnt_q == {{(TIMEOUT_W-1){1'b1}}, 1'b0};
    // Watchdog counter: counts consecutive memory stall cycles.
    always_ff @(posedge clk) begin
        wd_cnt_q <= reset ? '0 : wd_cnt_d;
    end
`else
    assign wd_trip = 1'b0;
`endif

    // State and multdiv counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            md_cnt_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    // Next-state and counter update.
    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        case (state_q)
            S_FETCH:  state_d = pc_zero ? S_HALT : waitrequest ? S_FETCH : S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (is_mem) begin
                    state_d = waitrequest ? S_EXEC : S_FETCH;
                end else if (is_md && !MD_ONE) begin
                    state_d  = S_MDWAIT;
                    md_cnt_d = MD_INIT;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MDWAIT: begin
                state_d  = md_cnt_q == 8'd0 ? S_FETCH : S_MDWAIT;
                md_cnt_d = md_cnt_q == 8'd0 ? 8'd0 : md_cnt_q - 8'd1;
            end
            default:  state_d = state_q;
        endcase
        if (wd_trip) state_d = S_FAULT;
    end

    // Outputs: decoded from state, counters and inputs; forced to 0 during reset.
    always_comb begin
        state       = run ? state_q : S_FETCH;
        active      = run && state_q <= S_MDWAIT;
        read        = run && ((in_f && !pc_zero) || (in_e && is_load));
        write       = run && in_e && is_store;
        ir_load     = run && in_f && !pc_zero && !waitrequest;
        pc_we       = run && (md_done || (in_e && !is_md && !(is_mem && waitrequest)));
        reg_commit  = run && in_e && !is_md && !is_store && !(is_mem && waitrequest);
        hilo_commit = run && md_done;
        stall       = run && (mem_stall || in_m);
`ifdef SEQ_WATCHDOG_EN
        fault       = run && state_q == S_FAULT;
`else
        fault       = 1'b0;
`endif
    end
endmodule

// File: doc/mips_sequencer.md
MIPS_SEQUENCER -- requirements
Module: mips_sequencer

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter MD_LATENCY, default 32: EXEC-to-commit cycle count for MULT/MULTU/DIV/DIVU; legal range 1..255.
REQ-003 Parameter TIMEOUT_W, default 8: watchdog counter width; legal range 2..16.
REQ-004 Ports (name  direction  width  meaning):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- opcode  in  6  instruction bits [31:26]; valid in DECODE and EXEC
- function_code  in  6  instruction bits [5:0]; valid in DECODE and EXEC
- waitrequest  in  1  Avalon memory stall
- pc_zero  in  1  current PC equals 0
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MDWAIT=3, HALT=4, FAULT=5
- active  out  1  CPU running
- read  out  1  Avalon read strobe
- write  out  1  Avalon write strobe
- ir_load  out  1  latch readdata into the instruction register
- pc_we  out  1  commit the next PC
- reg_commit  out  1  gates the register-file write enable
- hilo_commit  out  1  gates HI/LO write enable for mult/div
- stall  out  1  waitrequest stall or MDWAIT in progress
- fault  out  1  watchdog expired

Function
REQ-005 The state register and all counters SHALL be registered on rising clk; all outputs SHALL be combinational from state, counters and inputs.
REQ-006 Memory op SHALL mean opcode 32..38 (load, read) or 40, 41, 43 (store, write); multdiv SHALL mean opcode 0 with function_code 24..27.
REQ-007 FETCH with pc_zero=1 SHALL go to HALT with read=0.
REQ-008 FETCH with pc_zero=0 SHALL assert read=1; waitrequest=1 SHALL hold FETCH (stall=1); waitrequest=0 SHALL assert ir_load=1 and go to DECODE.
REQ-009 DECODE SHALL assert no strobes and SHALL go to EXEC after exactly 1 cycle.
REQ-010 EXEC with a memory op SHALL assert read or write; while waitrequest=1 it SHALL hold EXEC with the strobe asserted and stall=1.
REQ-011 When waitrequest=0 in EXEC with a memory op, the block SHALL pulse pc_we=1 and reg_commit=1 (loads only) and go to FETCH.
REQ-012 EXEC with multdiv and MD_LATENCY=1 SHALL pulse pc_we and hilo_commit and go to FETCH.
REQ-013 EXEC with multdiv and MD_LATENCY>1 SHALL load md_cnt=MD_LATENCY-2 and go to MDWAIT.
REQ-014 Any other EXEC instruction SHALL pulse pc_we=1 and reg_commit=1 for 1 cycle and go to FETCH; reg_commit is gated downstream by the decoder's write enable.
REQ-015 MDWAIT SHALL assert stall=1 and decrement md_cnt each cycle.
REQ-016 MDWAIT at md_cnt=0 SHALL pulse pc_we=1 and hilo_commit=1 and go to FETCH; a multdiv instruction therefore spends MD_LATENCY cycles from EXEC entry to commit.
REQ-017 Latency: a non-memory, non-multdiv instruction with no stalls SHALL take 3 cycles (FETCH, DECODE, EXEC).
REQ-018 HALT SHALL be sticky until reset: active=0 and all strobes 0.
REQ-019 active SHALL be 1 in FETCH, DECODE, EXEC and MDWAIT, and 0 in HALT and FAULT.
REQ-020 pc_we, ir_load, reg_commit and hilo_commit SHALL each assert for at most 1 cycle per instruction, and read and write SHALL never be asserted together.

Reset
REQ-021 reset=1 SHALL take priority over every transition, including mid-wait and in HALT or FAULT.
REQ-022 On the next edge, reset SHALL set state to FETCH, md_cnt to 0 and wd_cnt to 0.
REQ-023 While reset=1, all outputs SHALL be 0 and state SHALL read 0.
REQ-024 On the first cycle after reset deasserts, the block SHALL be in FETCH with active=1 and read=1 (if pc_zero=0).

Configuration
REQ-025 The macro SEQ_WATCHDOG_EN SHALL compile the waitrequest watchdog in or out.
REQ-026 With SEQ_WATCHDOG_EN defined, wd_cnt SHALL increment on each cycle with waitrequest=1 in FETCH or EXEC-memory and clear on any other cycle.
REQ-027 With SEQ_WATCHDOG_EN defined, reaching 2^TIMEOUT_W-1 SHALL go to FAULT on the next edge; FAULT drives fault=1, active=0, all strobes 0, and holds until reset.
REQ-028 With SEQ_WATCHDOG_EN undefined, the block SHALL have no wd_cnt, SHALL tie fault to 0, SHALL make FAULT unreachable, and SHALL wait indefinitely.

Verification
REQ-029 ADDU (op 0, fn 33), no waitrequest -> states 0,1,2,0; single-cycle pc_we and reg_commit in the EXEC cycle; 3 cycles per instruction.
REQ-030 LW (op 35), waitrequest=1 for 4 cycles in EXEC -> read held 5 cycles, stall=1 for 4; reg_commit and pc_we pulse on the 5th.
REQ-031 MULT (op 0, fn 24), MD_LATENCY=4 -> EXEC, then MDWAIT for 3 cycles; hilo_commit and pc_we pulse on the last MDWAIT cycle; reg_commit stays 0.
REQ-032 pc_zero=1 in FETCH -> HALT next cycle, active=0, read=0 thereafter; reset -> FETCH with read=1.
REQ-033 SEQ_WATCHDOG_EN, TIMEOUT_W=3, waitrequest held 1 in FETCH -> FAULT after 7 stall cycles, fault=1; with the macro undefined, FETCH is held for 100 cycles with fault=0.
REQ-034 reset asserted on cycle 2 of MDWAIT -> the next state is FETCH with md_cnt=0 and no hilo_commit.
